avalon_mm_reg_master: RTL and testbench
=======================================

Name: avalon_mm_reg_master

Overview:
- Avalon-MM master that turns single register-access commands into Avalon-MM read/write transfers.
- Drives a register slave such as registers_controller; it sits between a command source (loopback/debug command decoder) and the register bus.
- One transfer is outstanding at a time. Every command returns exactly one response: read data, or a timeout error.

Parameters:
- ADDR_W, 32, width of cmd_addr and mm_address.
- DATA_W, 32, width of write/read data.
- ADDR_BASE, 0, constant added to cmd_addr to form mm_address (modulo 2^ADDR_W).
- TIMEOUT, 255, maximum cycles in REQ or RD_WAIT before aborting; must be >= 1; counter width $clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  register offset
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  DATA_W  read data; 0 for writes and for errors
- rsp_err  out  1  transfer timed out
- mm_address  out  ADDR_W  Avalon address
- mm_read  out  1  Avalon read
- mm_write  out  1  Avalon write
- mm_writedata  out  DATA_W  Avalon write data
- mm_waitrequest  in  1  slave stall (tie 0 if the slave has none)
- mm_readdata  in  DATA_W  Avalon read data
- mm_readdatavalid  in  1  read data valid

Behaviour:
- Single clock clk. rst_n is asynchronous, active-low. All flops clear immediately on rst_n=0.
- Reset values: state=IDLE, cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mm_read=0, mm_write=0, mm_address=0, mm_writedata=0, timeout counter=0.
- cmd_ready=1 only in IDLE (registered). All mm_* outputs are registered.
- IDLE:
  - On command handshake, latch mm_address=ADDR_BASE+cmd_addr and mm_writedata=cmd_wdata (read: writedata=0).
  - Assert mm_write or mm_read next cycle; go to REQ; clear counter.
- REQ:
  - Hold address, data and strobe stable while mm_waitrequest=1; counter increments each such cycle.
  - Cycle with mm_waitrequest=0:
    - Write: deassert strobe; rsp_err=0, rsp_rdata=0; go to RESP.
    - Read: deassert mm_read; clear counter; go to RD_WAIT.
    - Read with mm_readdatavalid=1 in that same cycle (zero-latency slave): capture mm_readdata and go directly to RESP.
  - Counter reaches TIMEOUT while waitrequest=1: drop strobe; rsp_err=1, rsp_rdata=0; go to RESP.
- RD_WAIT:
  - mm_readdatavalid=1: rsp_rdata=mm_readdata, rsp_err=0; go to RESP.
  - Otherwise the counter increments; at TIMEOUT, rsp_err=1, rsp_rdata=0; go to RESP.
  - mm_readdatavalid in any state other than RD_WAIT/REQ-read is ignored, e.g. a late response after timeout.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err held stable until rsp_ready.
  - On handshake: rsp_valid=0 next cycle, go to IDLE, cmd_ready=1.
  - No new command is accepted in the same cycle as a response handshake.
- Latency (waitrequest=0, slave readdatavalid one cycle after read): write accept -> rsp_valid 2 cycles; read accept -> rsp_valid 3 cycles.
- mm_read and mm_write are never asserted together.
- Reset mid-transfer: strobes drop asynchronously; any pending response is discarded.

Decomposition:
- Package reg_master_pkg: state enum typedef (IDLE, REQ, RD_WAIT, RESP), and DEFAULT_TIMEOUT constant.
- Optional sub-module timeout_counter with clear, enable and expired outputs, parameterised by TIMEOUT.
- FSM and datapath stay in the top module.

Test Plan:
- Write via cmd (addr 'h2, wdata 'hdeadbeef) into registers_controller, ADDR_BASE=0 -> mm_write=1 with mm_address='h2 for one cycle; rsp_valid with rsp_err=0 after 2 cycles.
- Read back addr 'h2 -> mm_read for one cycle; rsp_rdata='hdeadbeef, rsp_err=0.
- Read addr 'h0 before and after 10 cycles of msg_enter=1 -> second rsp_rdata exceeds the first by 10.
- mm_waitrequest held high for 3 cycles on a write of 'h12345678 -> address/data stable all 4 cycles; single response, rsp_err=0.
- TIMEOUT=8, slave never asserts readdatavalid -> rsp_err=1 and rsp_rdata=0 after the timeout; a late mm_readdatavalid is ignored; the next command completes normally.
- rsp_ready held low for 5 cycles, then rst_n pulsed low during a REQ -> response stays stable while stalled; after reset all outputs are at reset values and cmd_ready=1.

Source files
------------

// File: rtl/reg_master_pkg.sv
// Shared types and constants for the Avalon-MM register master.
package reg_master_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } state_e;

  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/timeout_counter.sv
// Stall-cycle counter: expired fires on the enabled cycle that brings the count to TIMEOUT.
module timeout_counter
  import reg_master_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q, count_d;

  // NOTE: every _d is given its default first, so no path through the block can infer a latch.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CW'(1);
    end
  end

  assign expired = enable && !clear && (count_q == CW'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/avalon_mm_reg_master.sv
// Turns single register commands into Avalon-MM transfers, one outstanding at a time,
// returning read data or a timeout error for every command.
module avalon_mm_reg_master
  import reg_master_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] ADDR_BASE = '0,
  parameter int                TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mm_address,
  output logic              mm_read,
  output logic              mm_write,
  output logic [DATA_W-1:0] mm_writedata,
  input  logic              mm_waitrequest,
  input  logic [DATA_W-1:0] mm_readdata,
  input  logic              mm_readdatavalid
);

  state_e            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              mm_read_q, mm_read_d;
  logic              mm_write_q, mm_write_d;
  logic [ADDR_W-1:0] mm_address_q, mm_address_d;
  logic [DATA_W-1:0] mm_writedata_q, mm_writedata_d;
  logic              cnt_clear, cnt_enable, cnt_expired;

  timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .expired(cnt_expired)
  );

  always_comb begin
    state_d        = state_q;
    cmd_ready_d    = cmd_ready_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_err_d      = rsp_err_q;
    mm_read_d      = mm_read_q;
    mm_write_d     = mm_write_q;
    mm_address_d   = mm_address_q;
    mm_writedata_d = mm_writedata_q;
    cnt_clear      = 1'b0;
    cnt_enable     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          mm_address_d   = ADDR_BASE + cmd_addr;
          mm_writedata_d = cmd_write ? cmd_wdata : '0;
          mm_write_d     = cmd_write;
          mm_read_d      = !cmd_write;
          cmd_ready_d    = 1'b0;
          cnt_clear      = 1'b1;
          state_d        = REQ;
        end
      end

      REQ: begin
        if (mm_waitrequest) begin
          cnt_enable = 1'b1;
          if (cnt_expired) begin
            mm_write_d  = 1'b0;
            mm_read_d   = 1'b0;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end
        end else if (mm_write_q) begin
          mm_write_d  = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          mm_read_d = 1'b0;
          // A zero-latency slave returns data in the same cycle it accepts the read.
          if (mm_readdatavalid) begin
            rsp_rdata_d = mm_readdata;
            rsp_err_d   = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end else begin
            cnt_clear = 1'b1;
            state_d   = RD_WAIT;
          end
        end
      end

      RD_WAIT: begin
        if (mm_readdatavalid) begin
          rsp_rdata_d = mm_readdata;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_enable = 1'b1;
          if (cnt_expired) begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cmd_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_err_q      <= 1'b0;
      mm_read_q      <= 1'b0;
      mm_write_q     <= 1'b0;
      mm_address_q   <= '0;
      mm_writedata_q <= '0;
    end else begin
      state_q        <= state_d;
      cmd_ready_q    <= cmd_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_err_q      <= rsp_err_d;
      mm_read_q      <= mm_read_d;
      mm_write_q     <= mm_write_d;
      mm_address_q   <= mm_address_d;
      mm_writedata_q <= mm_writedata_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign mm_read      = mm_read_q;
  assign mm_write     = mm_write_q;
  assign mm_address   = mm_address_q;
  assign mm_writedata = mm_writedata_q;

endmodule

// File: tb/tb_avalon_mm_reg_master.sv
// Self-checking bench: behavioural register slave plus a command-level reference model.
module tb_avalon_mm_reg_master;

  localparam int          TO   = 8;
  localparam logic [31:0] BASE = 32'hFFFF_FFF0;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mm_address, mm_writedata, mm_readdata;
  logic        mm_read, mm_write, mm_waitrequest, mm_readdatavalid;

  int checks   = 0;
  int failures = 0;

  avalon_mm_reg_master #(
    .ADDR_W(32), .DATA_W(32), .ADDR_BASE(BASE), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mm_address(mm_address), .mm_read(mm_read), .mm_write(mm_write),
    .mm_writedata(mm_writedata), .mm_waitrequest(mm_waitrequest),
    .mm_readdata(mm_readdata), .mm_readdatavalid(mm_readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave configuration: cfg_wait<0 stalls forever, cfg_lat<0 never returns read data.
  int          cfg_wait = 0;
  int          cfg_lat  = 1;
  logic        msg_enter  = 1'b0;
  logic        late_pulse = 1'b0;
  logic [31:0] cnt_reg = 32'd100;
  int          unstable = 0;
  int          both_hi  = 0;
  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          cycles;
  } xfer_t;
  xfer_t xq[$];

  // Register slave; address BASE+0 is a message counter bumped while msg_enter is high.
  initial begin
    logic        active;
    int          wait_left, rd_cnt, scyc;
    logic [31:0] a, d, rd_val;
    logic        w;
    active = 1'b0; rd_cnt = -1; scyc = 0; wait_left = 0;
    a = '0; d = '0; w = 1'b0; rd_val = '0;
    mm_waitrequest = 1'b0; mm_readdatavalid = 1'b0; mm_readdata = '0;
    forever begin
      @(negedge clk);
      if (msg_enter) cnt_reg = cnt_reg + 1;
      mm_readdatavalid = 1'b0;
      mm_readdata      = $urandom;
      if (rd_cnt > 0) begin
        rd_cnt = rd_cnt - 1;
        if (rd_cnt == 0) begin
          mm_readdatavalid = 1'b1;
          mm_readdata      = rd_val;
          rd_cnt           = -1;
        end
      end
      if (late_pulse) begin
        mm_readdatavalid = 1'b1;
        mm_readdata      = 32'hBAD0_BAD0;
        late_pulse       = 1'b0;
      end
      if (!rst_n) begin
        active = 1'b0; rd_cnt = -1; mm_waitrequest = 1'b0;
      end else if (mm_read || mm_write) begin
        if (mm_read && mm_write) both_hi++;
        if (!active) begin
          active = 1'b1; a = mm_address; d = mm_writedata; w = mm_write;
          scyc = 0; wait_left = cfg_wait;
        end else if (mm_address !== a || mm_writedata !== d || mm_write !== w) begin
          unstable++;
        end
        scyc++;
        if (wait_left != 0) begin
          mm_waitrequest = 1'b1;
          if (wait_left > 0) wait_left--;
        end else begin
          mm_waitrequest = 1'b0;
          if (w) begin
            if (a != BASE) slave_mem[a] = d;
          end else begin
            rd_val = (a == BASE) ? cnt_reg : (slave_mem.exists(a) ? slave_mem[a] : 32'h0);
            if (cfg_lat == 0) begin
              mm_readdatavalid = 1'b1;
              mm_readdata      = rd_val;
            end else if (cfg_lat > 0) begin
              rd_cnt = cfg_lat;
            end
          end
        end
      end else begin
        if (active) xq.push_back('{wr: w, addr: a, data: d, cycles: scyc});
        active = 1'b0;
        mm_waitrequest = 1'b0;
      end
    end
  end

  // Issues one command, waits (bounded) for the response, stalls rsp_ready, then consumes it.
  task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input int ready_delay, output logic [31:0] rdata, output logic err,
                        output int lat, output logic stall_ok);
    int          guard;
    logic        got;
    logic [31:0] r0;
    logic        e0;
    xq.delete();
    @(negedge clk);
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_write = $urandom; cmd_addr = $urandom; cmd_wdata = $urandom;
    lat = 0; got = 1'b0;
    while (!got && lat < 4 * TO + 20) begin
      @(negedge clk);
      lat++;
      got = (rsp_valid === 1'b1);
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL rsp_arrival: rsp_valid=0 after %0d cycles, required 1", lat);
    end
    stall_ok = 1'b1; r0 = rsp_rdata; e0 = rsp_err;
    repeat (ready_delay) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== r0 || rsp_err !== e0) stall_ok = 1'b0;
    end
    rdata = rsp_rdata; err = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, mm_read, mm_write} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_flags: got %b, required 10000",
               {cmd_ready, rsp_valid, rsp_err, mm_read, mm_write});
    end
    checks++;
    if (rsp_rdata !== 32'h0 || mm_address !== 32'h0 || mm_writedata !== 32'h0) begin
      failures++;
      $display("FAIL reset_data: rdata=%h addr=%h wdata=%h, required all 0",
               rsp_rdata, mm_address, mm_writedata);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er, st; int lat;
    cfg_wait = 0; cfg_lat = 1;
    do_cmd(1'b1, 32'h2, 32'hDEADBEEF, 0, rd, er, lat, st);
    ref_mem[32'h2] = 32'hDEADBEEF;
    checks++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h0) begin
      failures++;
      $display("FAIL write_rsp: lat=%0d err=%b rdata=%h, required 2 0 0", lat, er, rd);
    end
    checks++;
    if (xq.size() != 1 || xq[0].wr !== 1'b1 || xq[0].addr !== BASE + 32'h2 ||
        xq[0].data !== 32'hDEADBEEF || xq[0].cycles != 1) begin
      failures++;
      $display("FAIL write_bus: n=%0d addr=%h data=%h cycles=%0d, required 1 %h deadbeef 1",
               xq.size(), xq.size() ? xq[0].addr : 0, xq.size() ? xq[0].data : 0,
               xq.size() ? xq[0].cycles : 0, BASE + 32'h2);
    end
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL after_handshake: rsp_valid=%b cmd_ready=%b, required 0 1", rsp_valid, cmd_ready);
    end
    do_cmd(1'b0, 32'h2, 32'h0, 0, rd, er, lat, st);
    checks++;
    if (lat !== 3 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL read_rsp: lat=%0d err=%b rdata=%h, required 3 0 deadbeef", lat, er, rd);
    end
    checks++;
    if (xq.size() != 1 || xq[0].wr !== 1'b0 || xq[0].addr !== BASE + 32'h2 ||
        xq[0].data !== 32'h0 || xq[0].cycles != 1) begin
      failures++;
      $display("FAIL read_bus: n=%0d addr=%h data=%h, required 1 %h 0",
               xq.size(), xq.size() ? xq[0].addr : 0, xq.size() ? xq[0].data : 0, BASE + 32'h2);
    end
    cfg_lat = 0;
    do_cmd(1'b0, 32'h2, 32'h0, 0, rd, er, lat, st);
    checks++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL zero_latency_read: lat=%0d err=%b rdata=%h, required 2 0 deadbeef", lat, er, rd);
    end
    cfg_lat = 1;
  endtask

  task automatic test_counter();
    logic [31:0] r0, r1; logic er, st; int lat;
    do_cmd(1'b0, 32'h0, 32'h0, 0, r0, er, lat, st);
    @(posedge clk); #1 msg_enter = 1'b1;
    repeat (10) @(posedge clk);
    #1 msg_enter = 1'b0;
    do_cmd(1'b0, 32'h0, 32'h0, 0, r1, er, lat, st);
    checks++;
    if (r1 - r0 !== 32'd10) begin
      failures++;
      $display("FAIL counter_delta: got %0d (first=%0d second=%0d), required 10", r1 - r0, r0, r1);
    end
  endtask

  task automatic test_waitrequest();
    logic [31:0] rd; logic er, st; int lat;
    cfg_wait = 3; unstable = 0;
    do_cmd(1'b1, 32'h5, 32'h12345678, 0, rd, er, lat, st);
    ref_mem[32'h5] = 32'h12345678;
    checks++;
    if (lat !== 5 || er !== 1'b0) begin
      failures++;
      $display("FAIL wait_write_rsp: lat=%0d err=%b, required 5 0", lat, er);
    end
    checks++;
    if (xq.size() != 1 || xq[0].cycles != 4 || xq[0].data !== 32'h12345678 || unstable != 0) begin
      failures++;
      $display("FAIL wait_write_bus: n=%0d cycles=%0d unstable=%0d, required 1 4 0",
               xq.size(), xq.size() ? xq[0].cycles : 0, unstable);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || mm_write !== 1'b0) begin
      failures++;
      $display("FAIL single_response: rsp_valid=%b mm_write=%b, required 0 0", rsp_valid, mm_write);
    end
    cfg_wait = 0;
  endtask

  task automatic test_random();
    logic [31:0] rd, addr, data, exp_rd; logic er, st, wr; int lat, exp_lat;
    int bad_rsp = 0, bad_lat = 0, bad_bus = 0;
    both_hi = 0; unstable = 0;
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      addr = $urandom_range(8, 39);
      data = $urandom;
      cfg_wait = $urandom_range(0, 3);
      cfg_lat = $urandom_range(0, 3);
      exp_rd = wr ? 32'h0 : (ref_mem.exists(addr) ? ref_mem[addr] : 32'h0);
      exp_lat = 2 + cfg_wait + ((!wr && cfg_lat > 0) ? cfg_lat : 0);
      do_cmd(wr, addr, data, $urandom_range(0, 2), rd, er, lat, st);
      if (wr) ref_mem[addr] = data;
      checks++;
      if (rd !== exp_rd || er !== 1'b0) begin
        failures++; bad_rsp++;
        $display("FAIL rand_rsp[%0d]: rdata=%h err=%b, required %h 0", i, rd, er, exp_rd);
      end
      checks++;
      if (lat != exp_lat) begin
        failures++; bad_lat++;
        $display("FAIL rand_lat[%0d]: got %0d, required %0d", i, lat, exp_lat);
      end
      checks++;
      if (xq.size() != 1 || xq[0].wr !== wr || xq[0].addr !== BASE + addr ||
          xq[0].data !== (wr ? data : 32'h0) || xq[0].cycles != cfg_wait + 1) begin
        failures++; bad_bus++;
        $display("FAIL rand_bus[%0d]: n=%0d addr=%h, required 1 %h", i, xq.size(),
                 xq.size() ? xq[0].addr : 0, BASE + addr);
      end
    end
    checks++;
    if (both_hi != 0 || unstable != 0) begin
      failures++;
      $display("FAIL strobe_rules: both_high=%0d unstable=%0d, required 0 0", both_hi, unstable);
    end
    cfg_wait = 0; cfg_lat = 1;
  endtask

  task automatic test_timeout();
    logic [31:0] rd; logic er, st; int lat;
    cfg_lat = -1;
    do_cmd(1'b0, 32'h2, 32'h0, 0, rd, er, lat, st);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0 || lat < TO + 1 || lat > TO + 2) begin
      failures++;
      $display("FAIL read_timeout: err=%b rdata=%h lat=%0d, required 1 0 %0d..%0d",
               er, rd, lat, TO + 1, TO + 2);
    end
    cfg_lat = 1;
    late_pulse = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL late_data_ignored: rsp_valid=%b cmd_ready=%b, required 0 1", rsp_valid, cmd_ready);
    end
    do_cmd(1'b0, 32'h2, 32'h0, 0, rd, er, lat, st);
    checks++;
    if (er !== 1'b0 || rd !== 32'hDEADBEEF || lat != 3) begin
      failures++;
      $display("FAIL post_timeout_read: err=%b rdata=%h lat=%0d, required 0 deadbeef 3", er, rd, lat);
    end
    cfg_wait = -1;
    do_cmd(1'b1, 32'h6, 32'hCAFEF00D, 0, rd, er, lat, st);
    cfg_wait = 0;
    checks++;
    if (er !== 1'b1 || rd !== 32'h0 || lat < TO || lat > TO + 1 || xq.size() != 1) begin
      failures++;
      $display("FAIL write_timeout: err=%b rdata=%h lat=%0d dropped=%0d, required 1 0 %0d..%0d 1",
               er, rd, lat, xq.size(), TO, TO + 1);
    end
  endtask

  task automatic test_stall_and_reset();
    logic [31:0] rd; logic er, st; int lat;
    do_cmd(1'b0, 32'h2, 32'h0, 5, rd, er, lat, st);
    checks++;
    if (st !== 1'b1 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      failures++;
      $display("FAIL stalled_rsp: stable=%b rdata=%h err=%b, required 1 deadbeef 0", st, rd, er);
    end
    cfg_wait = -1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h9; cmd_wdata = 32'h55AA55AA;
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (mm_write !== 1'b1) begin
      failures++;
      $display("FAIL req_before_reset: mm_write=%b, required 1", mm_write);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, mm_read, mm_write} !== 5'b10000 ||
        mm_address !== 32'h0 || mm_writedata !== 32'h0 || rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL async_reset: flags=%b addr=%h wdata=%h, required 10000 0 0",
               {cmd_ready, rsp_valid, rsp_err, mm_read, mm_write}, mm_address, mm_writedata);
    end
    cfg_wait = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || mm_write !== 1'b0) begin
      failures++;
      $display("FAIL after_reset: rsp_valid=%b cmd_ready=%b mm_write=%b, required 0 1 0",
               rsp_valid, cmd_ready, mm_write);
    end
    do_cmd(1'b0, 32'h2, 32'h0, 0, rd, er, lat, st);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat != 3) begin
      failures++;
      $display("FAIL post_reset_read: rdata=%h err=%b lat=%0d, required deadbeef 0 3", rd, er, lat);
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_counter();
    test_waitrequest();
    test_random();
    test_timeout();
    test_stall_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1ms, required to finish");
    $fatal(1, "watchdog expired");
  end

endmodule
